// File: rtl/sdcmd_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sdcmd_responder                                              |
// | Description : Device-side SD/eMMC CMD-line engine. It receives 48-bit host |
// |               commands with a CRC7 check and presents them over a          |
// |               valid/ready handshake, then sends R1/R3 (or R2 when          |
// |               SDCMD_RESPONDER_R2_EN is defined) after the NCR gap.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sdcmd_responder #(
  parameter int NCR = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_ck_stb,
  input  logic         i_cmd,
  output logic         o_cmd,
  output logic         o_cmd_en,
  output logic         o_cmd_valid,
  input  logic         i_cmd_ready,
  output logic [5:0]   o_cmd_idx,
  output logic [31:0]  o_cmd_arg,
  output logic         o_cmd_crcerr,
  input  logic         i_rsp_valid,
  output logic         o_rsp_ready,
  input  logic [1:0]   i_rsp_type,
  input  logic [5:0]   i_rsp_idx,
  input  logic [127:0] i_rsp_data,
  output logic         o_busy
);

`ifdef SDCMD_RESPONDER_R2_EN
  localparam int         c_SR_W     = 136;
  localparam logic [7:0] c_LEN_LONG = 8'd136;
`else
  localparam int         c_SR_W     = 48;
`endif
  localparam logic [7:0] c_LEN_SHORT = 8'd48;
  localparam logic [5:0] c_NCR       = 6'(NCR);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RX       = 3'd1,
    S_PRESENT  = 3'd2,
    S_WAIT_RSP = 3'd3,
    S_GAP      = 3'd4,
    S_TX       = 3'd5
  } state_t;

  state_t            r_state;
  logic [44:0]       r_rx;
  logic [5:0]        r_rx_cnt;
  logic [6:0]        r_rx_crc;
  logic [5:0]        r_gap_cnt;
  logic [c_SR_W-1:0] r_tx_sr;
  logic [7:0]        r_tx_cnt;
  logic              r_cmd;
  logic              r_cmd_en;
  logic              r_cmd_valid;
  logic              r_rsp_ready;
  logic              r_crcerr;
  logic [5:0]        r_idx;
  logic [31:0]       r_arg;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = crc[6] ^ bit_in;
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // Leading zeros leave a zero-initialised CRC7 untouched, so short messages are right-aligned.
  function automatic logic [6:0] crc7_msg(input logic [119:0] msg);
    logic [6:0] c;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      c = crc7_step(c, msg[i]);
    end
    return c;
  endfunction

  logic [6:0]        w_r1_crc;
  logic [47:0]       w_frame_short;
  logic [c_SR_W-1:0] w_frame;
  logic [7:0]        w_frame_len;
  logic              w_rsp_none;
  logic [5:0]        w_gap_next;

  assign w_r1_crc   = crc7_msg({80'b0, 2'b00, i_rsp_idx, i_rsp_data[31:0]});
  assign w_gap_next = (r_gap_cnt == 6'h3F) ? r_gap_cnt : r_gap_cnt + 6'd1;

  always_comb begin
    w_frame_short = {2'b00, 6'h3F, i_rsp_data[31:0], 7'h7F, 1'b1};
    if (i_rsp_type == 2'b01) begin
      w_frame_short = {2'b00, i_rsp_idx, i_rsp_data[31:0], w_r1_crc, 1'b1};
    end
  end

`ifdef SDCMD_RESPONDER_R2_EN
  logic [6:0] w_r2_crc;
  assign w_r2_crc   = crc7_msg(i_rsp_data[127:8]);
  assign w_rsp_none = (i_rsp_type == 2'b00);

  always_comb begin
    w_frame     = {w_frame_short, 88'b0};
    w_frame_len = c_LEN_SHORT;
    if (i_rsp_type == 2'b10) begin
      w_frame     = {2'b00, 6'h3F, i_rsp_data[127:8], w_r2_crc, 1'b1};
      w_frame_len = c_LEN_LONG;
    end
  end
`else
  logic w_unused_data;
  assign w_unused_data = &{1'b0, i_rsp_data[127:32]};
  assign w_rsp_none    = (i_rsp_type == 2'b00) || (i_rsp_type == 2'b10);
  assign w_frame       = w_frame_short;
  assign w_frame_len   = c_LEN_SHORT;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_rx        <= '0;
      r_rx_cnt    <= '0;
      r_rx_crc    <= '0;
      r_gap_cnt   <= '0;
      r_tx_sr     <= '0;
      r_tx_cnt    <= '0;
      r_cmd       <= 1'b1;
      r_cmd_en    <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_rsp_ready <= 1'b0;
      r_crcerr    <= 1'b0;
      r_idx       <= '0;
      r_arg       <= '0;
    end else begin
      // The NCR gap is measured from the end-bit strobe through every waiting state.
      if (i_ck_stb && (r_state == S_PRESENT || r_state == S_WAIT_RSP || r_state == S_GAP)) begin
        r_gap_cnt <= w_gap_next;
      end

      case (r_state)
        S_IDLE: begin
          if (i_ck_stb && !i_cmd) begin
            r_state  <= S_RX;
            r_rx_cnt <= 6'd1;
            r_rx_crc <= '0;
          end
        end

        S_RX: begin
          if (i_ck_stb) begin
            r_rx     <= {r_rx[43:0], i_cmd};
            r_rx_cnt <= r_rx_cnt + 6'd1;
            if (r_rx_cnt < 6'd40) begin
              r_rx_crc <= crc7_step(r_rx_crc, i_cmd);
            end
            if (r_rx_cnt == 6'd1 && !i_cmd) begin
              r_state <= S_IDLE;
            end else if (r_rx_cnt == 6'd47) begin
              r_state     <= S_PRESENT;
              r_cmd_valid <= 1'b1;
              r_idx       <= r_rx[44:39];
              r_arg       <= r_rx[38:7];
              r_crcerr    <= (r_rx_crc != r_rx[6:0]) || !i_cmd;
              r_gap_cnt   <= '0;
            end
          end
        end

        S_PRESENT: begin
          if (i_cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_rsp_ready <= 1'b1;
            r_state     <= S_WAIT_RSP;
          end
        end

        S_WAIT_RSP: begin
          if (i_rsp_valid) begin
            r_rsp_ready <= 1'b0;
            if (w_rsp_none) begin
              r_state <= S_IDLE;
            end else begin
              r_tx_sr  <= w_frame;
              r_tx_cnt <= w_frame_len;
              r_state  <= S_GAP;
            end
          end
        end

        S_GAP: begin
          if (i_ck_stb && (w_gap_next >= c_NCR)) begin
            r_cmd_en <= 1'b1;
            r_cmd    <= r_tx_sr[c_SR_W-1];
            r_tx_sr  <= {r_tx_sr[c_SR_W-2:0], 1'b0};
            r_tx_cnt <= r_tx_cnt - 8'd1;
            r_state  <= S_TX;
          end
        end

        S_TX: begin
          if (i_ck_stb) begin
            if (r_tx_cnt != 8'd0) begin
              r_cmd    <= r_tx_sr[c_SR_W-1];
              r_tx_sr  <= {r_tx_sr[c_SR_W-2:0], 1'b0};
              r_tx_cnt <= r_tx_cnt - 8'd1;
            end else begin
              r_cmd_en <= 1'b0;
              r_cmd    <= 1'b1;
              r_state  <= S_IDLE;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cmd        = r_cmd;
  assign o_cmd_en     = r_cmd_en;
  assign o_cmd_valid  = r_cmd_valid;
  assign o_rsp_ready  = r_rsp_ready;
  assign o_cmd_idx    = r_idx;
  assign o_cmd_arg    = r_arg;
  assign o_cmd_crcerr = r_crcerr;
  assign o_busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sdcmd_responder.sv
`default_nettype none
// Randomized bench for sdcmd_responder: frames and response timing are derived
// from the protocol rules and the CMD line is compared every cycle.
module tb_sdcmd_responder;
  localparam int NCR = 2;

  logic         clk = 1'b0;
  logic         i_reset, i_ck_stb, i_cmd, i_cmd_ready, i_rsp_valid;
  logic [1:0]   i_rsp_type;
  logic [5:0]   i_rsp_idx;
  logic [127:0] i_rsp_data;
  logic         o_cmd, o_cmd_en, o_cmd_valid, o_cmd_crcerr, o_rsp_ready, o_busy;
  logic [5:0]   o_cmd_idx;
  logic [31:0]  o_cmd_arg;

  always #5 clk = ~clk;

  sdcmd_responder #(.NCR(NCR)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_ck_stb(i_ck_stb), .i_cmd(i_cmd),
    .o_cmd(o_cmd), .o_cmd_en(o_cmd_en), .o_cmd_valid(o_cmd_valid),
    .i_cmd_ready(i_cmd_ready), .o_cmd_idx(o_cmd_idx), .o_cmd_arg(o_cmd_arg),
    .o_cmd_crcerr(o_cmd_crcerr), .i_rsp_valid(i_rsp_valid), .o_rsp_ready(o_rsp_ready),
    .i_rsp_type(i_rsp_type), .i_rsp_idx(i_rsp_idx), .i_rsp_data(i_rsp_data),
    .o_busy(o_busy)
  );

  int checks = 0;
  int errors = 0;
  int stb_n  = 0;

  // Expected line activity: frame bits on strobes [exp_start, exp_start+exp_len).
  int           exp_start = 0;
  int           exp_len   = 0;
  logic [135:0] exp_frame = '0;
  bit           chk_en    = 0;
  int           obs_start = -1;
  logic         prev_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7_model(input logic [119:0] msg);
    logic [126:0] r;
    r = {msg, 7'b0};
    for (int i = 126; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_model({80'b0, 2'b01, idx, arg}), 1'b1};
  endfunction

  function automatic void exp_rsp(input logic [1:0] t, input logic [5:0] ridx,
                                  input logic [127:0] d, output logic [135:0] fr, output int len);
    fr  = '0;
    len = 0;
    case (t)
      2'b01: begin
        fr[135:88] = {2'b00, ridx, d[31:0], crc7_model({80'b0, 2'b00, ridx, d[31:0]}), 1'b1};
        len = 48;
      end
      2'b11: begin
        fr[135:88] = {2'b00, 6'h3F, d[31:0], 7'h7F, 1'b1};
        len = 48;
      end
      2'b10: begin
`ifdef SDCMD_RESPONDER_R2_EN
        fr  = {2'b00, 6'h3F, d[127:8], crc7_model(d[127:8]), 1'b1};
        len = 136;
`endif
      end
      default: ;
    endcase
  endfunction

  always @(posedge clk) if (i_ck_stb) stb_n <= stb_n + 1;

  initial begin
    i_ck_stb = 1'b0;
    forever begin
      repeat ($urandom_range(2, 4)) begin
        @(posedge clk); #1 i_ck_stb = 1'b0;
      end
      @(posedge clk); #1 i_ck_stb = 1'b1;
    end
  end

  always @(negedge clk) begin
    int s;
    bit drv;
    if (chk_en) begin
      s   = stb_n;
      drv = (exp_len > 0) && (s >= exp_start) && (s < exp_start + exp_len);
      check("line_en", 32'(o_cmd_en), 32'(drv));
      if (drv) check("line_bit", 32'(o_cmd), 32'(exp_frame[135 - (s - exp_start)]));
      if (o_cmd_en === 1'b1 && prev_en !== 1'b1) obs_start = s;
      prev_en = o_cmd_en;
    end
  end

  task automatic wait_strobe();
    do @(posedge clk); while (!i_ck_stb);
    #1;
  endtask

  task automatic send_bits(input logic [47:0] f, input int n);
    for (int i = 47; i > 47 - n; i--) begin
      i_cmd = f[i];
      wait_strobe();
    end
    i_cmd = 1'b1;
  endtask

  task automatic wait_stb_count(input int target, input string name);
    int guard;
    guard = 0;
    while (stb_n < target && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 5000) check(name, 32'(stb_n), 32'(target));
  endtask

  // exact: 1 = start must sit exactly NCR strobes after the end bit, 2 = first strobe after handshake.
  task automatic run_txn(input logic [47:0] f, input logic [1:0] rtype, input logic [5:0] ridx,
                         input logic [127:0] rdata, input int rdy_dly, input int rsp_dly,
                         input int abort_at, input int exact);
    int e, h, len, start;
    logic [135:0] fr;
    bit exp_err;
    exp_err = (crc7_model({80'b0, f[47:8]}) != f[7:1]) || !f[0];
    send_bits(f, 48);
    e = stb_n;
    check("cmd_valid_rise", 32'(o_cmd_valid), 32'd1);
    check("cmd_idx", 32'(o_cmd_idx), 32'(f[45:40]));
    check("cmd_arg", o_cmd_arg, f[39:8]);
    check("cmd_crcerr", 32'(o_cmd_crcerr), 32'(exp_err));
    check("busy_present", 32'(o_busy), 32'd1);
    check("rsp_ready_early", 32'(o_rsp_ready), 32'd0);
    repeat (rdy_dly) begin @(posedge clk); #1; end
    check("cmd_valid_hold", 32'(o_cmd_valid), 32'd1);
    i_cmd_ready = 1'b1;
    @(posedge clk); #1;
    i_cmd_ready = 1'b0;
    check("cmd_valid_fall", 32'(o_cmd_valid), 32'd0);
    check("rsp_ready_rise", 32'(o_rsp_ready), 32'd1);
    repeat (rsp_dly) wait_strobe();
    i_rsp_valid = 1'b1;
    i_rsp_type  = rtype;
    i_rsp_idx   = ridx;
    i_rsp_data  = rdata;
    @(posedge clk); #1;
    h = stb_n;
    i_rsp_valid = 1'b0;
    check("rsp_ready_fall", 32'(o_rsp_ready), 32'd0);
    exp_rsp(rtype, ridx, rdata, fr, len);
    if (len == 0) begin
      exp_len = 0;
      check("busy_no_rsp", 32'(o_busy), 32'd0);
    end else begin
      start     = (e + NCR > h + 1) ? e + NCR : h + 1;
      obs_start = -1;
      exp_frame = fr;
      exp_start = start;
      exp_len   = len;
      if (abort_at >= 0) begin
        wait_stb_count(start + abort_at, "abort_wait");
        i_reset = 1'b1;
        @(posedge clk); #1;
        exp_len = 0;
        check("abort_en", 32'(o_cmd_en), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        i_reset = 1'b0;
      end else begin
        wait_stb_count(start + len, "tx_wait");
        check("busy_after_tx", 32'(o_busy), 32'd0);
        check("start_strobe", 32'(obs_start), 32'(start));
        if (exact == 1) check("start_ncr", 32'(obs_start), 32'(e + NCR));
        if (exact == 2) check("start_late", 32'(obs_start), 32'(h + 1));
      end
    end
    repeat (2) wait_strobe();
  endtask

  initial begin
    bit seen;
    logic [47:0] f;
    logic [1:0] rt;
    int cr;
    i_reset = 1'b1; i_cmd = 1'b1; i_cmd_ready = 1'b0; i_rsp_valid = 1'b0;
    i_rsp_type = '0; i_rsp_idx = '0; i_rsp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd", 32'(o_cmd), 32'd1);
    check("rst_cmd_en", 32'(o_cmd_en), 32'd0);
    check("rst_cmd_valid", 32'(o_cmd_valid), 32'd0);
    check("rst_rsp_ready", 32'(o_rsp_ready), 32'd0);
    check("rst_crcerr", 32'(o_cmd_crcerr), 32'd0);
    check("rst_idx", 32'(o_cmd_idx), 32'd0);
    check("rst_arg", o_cmd_arg, 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    i_reset = 1'b0;
    chk_en  = 1;
    check("model_crc_cmd0", 32'(crc7_model({80'b0, 40'h40_0000_0000})), 32'h4A);
    check("model_crc_cmd8", 32'(crc7_model({80'b0, 40'h48_0000_01AA})), 32'h43);
    repeat (3) wait_strobe();

    run_txn(48'h40_0000_0000_95, 2'b00, 6'd0, 128'd0, 0, 0, -1, 0);
    run_txn(48'h48_0000_01AA_87, 2'b01, 6'd8, 128'h1AA, 0, 0, -1, 1);
    run_txn(48'h48_0000_01AA_86, 2'b00, 6'd0, 128'd0, 1, 0, -1, 0);

    send_bits(48'h08_0000_01AA_87, 2);
    seen = 0;
    repeat (60) begin
      wait_strobe();
      if (o_cmd_valid !== 1'b0) seen = 1;
    end
    check("drop_no_valid", 32'(seen), 32'd0);
    check("drop_busy", 32'(o_busy), 32'd0);

    run_txn(mk_cmd(6'd2, 32'd0), 2'b10, 6'd0, 128'h0123456789ABCDEF0123456789ABCDEF, 0, 0, -1, 0);
    run_txn(48'h48_0000_01AA_87, 2'b01, 6'd8, 128'h1AA, 2, 20, -1, 2);
    run_txn(mk_cmd(6'd17, 32'h0000_0200), 2'b01, 6'd17, 128'h900, 0, 0, 20, 0);
    run_txn(48'h40_0000_0000_95, 2'b11, 6'd0, 128'h00FF_8000, 0, 1, -1, 0);

    for (int n = 0; n < 30; n++) begin
      f  = mk_cmd(6'($urandom_range(0, 63)), $urandom);
      cr = $urandom_range(0, 5);
      if (cr == 1) f[1] = ~f[1];
      if (cr == 2) f[0] = 1'b0;
      rt = 2'($urandom_range(0, 3));
      run_txn(f, rt, 6'($urandom_range(0, 63)), {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(0, 5), $urandom_range(0, 6), -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/sdcmd_responder.md
# sdcmd_responder

Device-side SD/eMMC CMD-line engine: the card end of the command channel driven by `sdio_top`. It deserializes 48-bit host commands, checks CRC7, and hands index and argument to device logic over a valid/ready handshake. It then serializes the chosen response (R1/R3 48-bit or R2 136-bit) after the NCR gap. It forms the front end of synthesizable card models and loopback benches alongside `mdl_sdio`/`mdl_emmc`.

## Interface

- `NCR`, default 2: minimum SD-clock strobes from the command end bit to the response start bit; legal range 2..63.
- `i_clk`  in  1  system clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_ck_stb`  in  1  one-cycle SD-clock strobe; `i_cmd` is sampled and `o_cmd`/`o_cmd_en` update only in strobe cycles.
- `i_cmd`  in  1  CMD line input, already synchronized.
- `o_cmd`  out  1  CMD line drive value.
- `o_cmd_en`  out  1  CMD tristate drive enable.
- `o_cmd_valid`  out  1  received command available.
- `i_cmd_ready`  in  1  device logic accepts the command.
- `o_cmd_idx`  out  6  command index.
- `o_cmd_arg`  out  32  command argument.
- `o_cmd_crcerr`  out  1  CRC7 mismatch or end bit 0; qualified by `o_cmd_valid`.
- `i_rsp_valid`  in  1  response offered.
- `o_rsp_ready`  out  1  response accepted when high together with `i_rsp_valid`.
- `i_rsp_type`  in  2  response type: 00 none, 01 R1, 10 R2, 11 R3.
- `i_rsp_idx`  in  6  response index field (R1 only).
- `i_rsp_data`  in  128  payload: R1/R3 use [31:0]; R2 uses [127:8].
- `o_busy`  out  1  state is not IDLE.

## Operation

- States: IDLE, RX, PRESENT, WAIT_RSP, GAP, TX.
- **IDLE:** on a strobe with `i_cmd`=0, load the start bit and enter RX.
- **RX:** shift 47 more bits on strobes.
  - If the transmission bit (bit 46) is 0, the frame is another card's response: drop it and return to IDLE.
  - After bit 0 is captured, enter PRESENT.
- **CRC7:** polynomial x^7+x^3+1, initial value 0, computed over frame bits 47..8.
  - `o_cmd_crcerr`=1 if the computed CRC differs from bits 7..1 or bit 0 is 0.
- **PRESENT:** `o_cmd_valid`=1 with registered idx/arg/crcerr held stable. On `i_cmd_ready`, enter WAIT_RSP.
- **WAIT_RSP:** `o_rsp_ready`=1.
  - On accept with type 00, return to IDLE without driving the line.
  - Otherwise latch the frame into a 136-bit shift register and enter GAP.
- **Frame construction:**
  - R1: 0, 0, idx, data[31:0], CRC7 over the preceding 40 bits, 1.
  - R3: 0, 0, 111111, data[31:0], 1111111, 1.
  - R2: 0, 0, 111111, data[127:8], CRC7 over data[127:8], 1. data[7:0] is ignored.
- **GAP:** a 6-bit strobe counter starts at 0 on the strobe that captured the end bit and increments on every strobe in PRESENT/WAIT_RSP/GAP. The start bit is driven on the first strobe in GAP where counter ≥ `NCR`; enter TX.
- **TX:** on each strobe, drive the next MSB-first bit with `o_cmd_en`=1. On the strobe after the end bit, deassert `o_cmd_en` and enter IDLE.
- Line activity during PRESENT/WAIT_RSP/GAP/TX is ignored; no command is detected while responding.

## Timing

- Reset values: `o_cmd`=1, `o_cmd_en`=0, `o_cmd_valid`=0, `o_rsp_ready`=0, `o_cmd_crcerr`=0, `o_cmd_idx`=0, `o_cmd_arg`=0, `o_busy`=0; state IDLE.
- `o_cmd_valid` rises the i_clk cycle after the end-bit strobe and falls the cycle after the `i_cmd_ready` handshake.
- `o_rsp_ready` is high from the cycle after the command handshake until the cycle after the response handshake.
- Outputs are registered and change the i_clk cycle after the qualifying strobe.
- A response handed over late starts on the first strobe after the handshake.
- R1/R3 occupy 48 strobes; R2 occupies 136.
- Reset asserted mid-RX or mid-TX takes effect on the next i_clk edge regardless of `i_ck_stb`: `o_cmd_en`=0 and state IDLE.
- Handshake inputs are ignored outside their states.

## Configuration

- `SDCMD_RESPONDER_R2_EN` defined: R2 is supported with a 136-bit shift register.
- Undefined: the shift register is 48 bits, type 10 is treated as type 00 (no response), and `i_rsp_data[127:32]` is unused.

## Test plan

- Host sends CMD0 frame 0x40_00000000_95 -> `o_cmd_idx`=0, `o_cmd_arg`=0, `o_cmd_crcerr`=0.
- CMD8 frame 0x48_000001AA_87, then R1 response with idx 8, data 0x000001AA -> 48 bits output, start bit exactly `NCR` strobes after the end bit, CRC7 equal to the bench model, `o_cmd_en` dropped one strobe after the end bit.
- CMD8 frame with last byte 0x86 -> `o_cmd_crcerr`=1. Same frame with bit 46 cleared -> no `o_cmd_valid`, `o_busy` returns to 0.
- CMD2 with R2, data 0x0123...CDEF (high 120 bits) -> 136 bits, header 0x3F, CRC7 over data[127:8] in bits 7..1. With the macro undefined -> no drive.
- `i_rsp_valid` withheld for 20 strobes -> start bit on the first strobe after the handshake; line undriven until then.
- Reset pulsed during TX bit 20 -> `o_cmd_en`=0 the next cycle; a following CMD0 decodes correctly.
